// File: rtl/exe_mem_stage.sv
// -----------------------------------------------------------------------------
// exe_mem_stage
//
// Pipeline register between the EXE and MEM stages of an ARM-style core, plus
// the architectural status register (SR) and the condition-code evaluator.
//
// The EXE instruction's condition field is checked against the registered SR.
// A "commit" is a real, condition-passing instruction that is neither stalled
// nor annulled. Only committed instructions do three things:
//   - drive non-zero valid/enables to MEM
//   - update SR (if their S bit is set)
//   - advance commit_cnt
//
// Per-edge priority: rst > flush > freeze > normal capture.
//   flush  : valid and enables drop to 0; data, SR and counter hold
//            (this also applies while freeze is high)
//   freeze : every register holds
//   normal : data is captured unconditionally; valid/enables are gated by commit
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   freeze, flush        hazard stall / branch annul
//   valid_in, cond, s_in EXE instruction validity, condition field, S bit
//   alu_result, alu_sr   ALU result and flags {Z,C,N,V}
//   wb_en_in, mem_r_en_in, mem_w_en_in, dest_in, st_val_in   EXE control/data
//   cond_pass            combinational condition result (from registered SR)
//   sr_out               architectural status register {Z,C,N,V}
//   valid_out, wb_en_out, mem_r_en_out, mem_w_en_out,
//   alu_result_out, st_val_out, dest_out                     registered to MEM
//   commit_cnt           16-bit wrapping count of committed instructions
// -----------------------------------------------------------------------------
module exe_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic        valid_in,
    input  logic [3:0]  cond,
    input  logic        s_in,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_sr,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [3:0]  dest_in,
    input  logic [31:0] st_val_in,
    output logic        cond_pass,
    output logic [3:0]  sr_out,
    output logic        valid_out,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic        mem_w_en_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] st_val_out,
    output logic [3:0]  dest_out,
    output logic [15:0] commit_cnt
);

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Status register and MEM-side pipeline registers
    logic [3:0]  sr_q,         sr_d;
    logic        valid_q,      valid_d;
    logic        wb_en_q,      wb_en_d;
    logic        mem_r_en_q,   mem_r_en_d;
    logic        mem_w_en_q,   mem_w_en_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] st_val_q,     st_val_d;
    logic [3:0]  dest_q,       dest_d;
    logic [15:0] commit_cnt_q, commit_cnt_d;

    logic flag_z, flag_c, flag_n, flag_v;
    logic commit;

    // Flags come from the registered SR, so an S instruction only affects
    // the condition of the instruction after it.
    assign flag_z = sr_q[3];
    assign flag_c = sr_q[2];
    assign flag_n = sr_q[1];
    assign flag_v = sr_q[0];

    // -------------------------------------------------------------------------
    // Condition evaluation
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred even if a branch is later removed.
        cond_pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_pass = flag_z;
            COND_NE: cond_pass = ~flag_z;
            COND_CS: cond_pass = flag_c;
            COND_CC: cond_pass = ~flag_c;
            COND_MI: cond_pass = flag_n;
            COND_PL: cond_pass = ~flag_n;
            COND_VS: cond_pass = flag_v;
            COND_VC: cond_pass = ~flag_v;
            COND_HI: cond_pass = flag_c & ~flag_z;
            COND_LS: cond_pass = ~flag_c | flag_z;
            COND_GE: cond_pass = (flag_n == flag_v);
            COND_LT: cond_pass = (flag_n != flag_v);
            COND_GT: cond_pass = ~flag_z & (flag_n == flag_v);
            COND_LE: cond_pass = flag_z | (flag_n != flag_v);
            COND_AL: cond_pass = 1'b1;
            COND_NV: cond_pass = 1'b0;  // reserved "never" encoding
            default: cond_pass = 1'b0;
        endcase
    end

    assign commit = valid_in & cond_pass & ~flush & ~freeze;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Hold by default; this covers the freeze case and the data/SR/counter
        // part of the flush case.
        sr_d         = sr_q;
        valid_d      = valid_q;
        wb_en_d      = wb_en_q;
        mem_r_en_d   = mem_r_en_q;
        mem_w_en_d   = mem_w_en_q;
        alu_result_d = alu_result_q;
        st_val_d     = st_val_q;
        dest_d       = dest_q;
        commit_cnt_d = commit_cnt_q;

        if (flush) begin
            // Insert a bubble. Flush wins over freeze: a stalled, annulled
            // slot must not reach MEM later as a live instruction.
            valid_d    = 1'b0;
            wb_en_d    = 1'b0;
            mem_r_en_d = 1'b0;
            mem_w_en_d = 1'b0;
        end else if (!freeze) begin
            alu_result_d = alu_result;
            st_val_d     = st_val_in;
            dest_d       = dest_in;
            valid_d      = valid_in    & commit;
            wb_en_d      = wb_en_in    & commit;
            mem_r_en_d   = mem_r_en_in & commit;
            mem_w_en_d   = mem_w_en_in & commit;
            if (commit) begin
                commit_cnt_d = commit_cnt_q + 16'd1;  // wraps naturally at 0xFFFF
                if (s_in) begin
                    sr_d = alu_sr;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample the pre-edge
        // value of the others, independent of statement order.
        if (rst) begin
            sr_q         <= 4'b0000;
            valid_q      <= 1'b0;
            wb_en_q      <= 1'b0;
            mem_r_en_q   <= 1'b0;
            mem_w_en_q   <= 1'b0;
            alu_result_q <= 32'h0;
            st_val_q     <= 32'h0;
            dest_q       <= 4'h0;
            commit_cnt_q <= 16'h0;
        end else begin
            sr_q         <= sr_d;
            valid_q      <= valid_d;
            wb_en_q      <= wb_en_d;
            mem_r_en_q   <= mem_r_en_d;
            mem_w_en_q   <= mem_w_en_d;
            alu_result_q <= alu_result_d;
            st_val_q     <= st_val_d;
            dest_q       <= dest_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    assign sr_out         = sr_q;
    assign valid_out      = valid_q;
    assign wb_en_out      = wb_en_q;
    assign mem_r_en_out   = mem_r_en_q;
    assign mem_w_en_out   = mem_w_en_q;
    assign alu_result_out = alu_result_q;
    assign st_val_out     = st_val_q;
    assign dest_out       = dest_q;
    assign commit_cnt     = commit_cnt_q;

endmodule

// File: tb/tb_exe_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_mem_stage
//
// Directed self-checking bench for exe_mem_stage. Inputs are driven 1 ns after
// the rising edge; outputs are sampled 1 ns after the edge, or 1 ns after the
// inputs change when checking the combinational cond_pass.
// -----------------------------------------------------------------------------
module tb_exe_mem_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        valid_in;
    logic [3:0]  cond;
    logic        s_in;
    logic [31:0] alu_result;
    logic [3:0]  alu_sr;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic [3:0]  dest_in;
    logic [31:0] st_val_in;
    logic        cond_pass;
    logic [3:0]  sr_out;
    logic        valid_out;
    logic        wb_en_out;
    logic        mem_r_en_out;
    logic        mem_w_en_out;
    logic [31:0] alu_result_out;
    logic [31:0] st_val_out;
    logic [3:0]  dest_out;
    logic [15:0] commit_cnt;

    int n_vectors;
    int n_miscompares;

    exe_mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .flush          (flush),
        .valid_in       (valid_in),
        .cond           (cond),
        .s_in           (s_in),
        .alu_result     (alu_result),
        .alu_sr         (alu_sr),
        .wb_en_in       (wb_en_in),
        .mem_r_en_in    (mem_r_en_in),
        .mem_w_en_in    (mem_w_en_in),
        .dest_in        (dest_in),
        .st_val_in      (st_val_in),
        .cond_pass      (cond_pass),
        .sr_out         (sr_out),
        .valid_out      (valid_out),
        .wb_en_out      (wb_en_out),
        .mem_r_en_out   (mem_r_en_out),
        .mem_w_en_out   (mem_w_en_out),
        .alu_result_out (alu_result_out),
        .st_val_out     (st_val_out),
        .dest_out       (dest_out),
        .commit_cnt     (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        freeze      = 1'b0;
        flush       = 1'b0;
        valid_in    = 1'b0;
        cond        = 4'b1110;
        s_in        = 1'b0;
        alu_result  = 32'h0;
        alu_sr      = 4'b0000;
        wb_en_in    = 1'b0;
        mem_r_en_in = 1'b0;
        mem_w_en_in = 1'b0;
        dest_in     = 4'h0;
        st_val_in   = 32'h0;
    endtask

    // Checks every registered output against one expected set.
    task automatic check_regs(input string tag, input logic v, input logic wb, input logic mr,
                              input logic mw, input logic [31:0] res, input logic [31:0] st,
                              input logic [3:0] dst, input logic [3:0] sr, input logic [15:0] cnt);
        check({tag, ".valid"},  32'(valid_out),    32'(v));
        check({tag, ".wb"},     32'(wb_en_out),    32'(wb));
        check({tag, ".mr"},     32'(mem_r_en_out), 32'(mr));
        check({tag, ".mw"},     32'(mem_w_en_out), 32'(mw));
        check({tag, ".res"},    alu_result_out,    res);
        check({tag, ".st"},     st_val_out,        st);
        check({tag, ".dest"},   32'(dest_out),     32'(dst));
        check({tag, ".sr"},     32'(sr_out),       32'(sr));
        check({tag, ".cnt"},    32'(commit_cnt),   32'(cnt));
    endtask

    // Reference condition table, flags ordered {Z,C,N,V}.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic z, cf, n, v;
        z = f[3]; cf = f[2]; n = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        idle_inputs();

        // ---- Reset overrides flush, freeze and a live instruction ----
        rst         = 1'b1;
        freeze      = 1'b1;
        flush       = 1'b1;
        valid_in    = 1'b1;
        s_in        = 1'b1;
        alu_sr      = 4'b1111;
        wb_en_in    = 1'b1;
        alu_result  = 32'hFFFF_FFFF;
        st_val_in   = 32'hFFFF_FFFF;
        dest_in     = 4'hF;
        tick();
        tick();
        check_regs("reset", 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 4'h0, 16'h0);
        rst = 1'b0;
        idle_inputs();

        // Conditions against SR = 0000
        cond = 4'b0000; #1; check("rst_eq", 32'(cond_pass), 32'd0);
        cond = 4'b0001; #1; check("rst_ne", 32'(cond_pass), 32'd1);
        cond = 4'b1110; #1; check("rst_al", 32'(cond_pass), 32'd1);

        // ---- First committed S instruction ----
        valid_in   = 1'b1;
        cond       = 4'b1110;
        s_in       = 1'b1;
        alu_sr     = 4'b1000;
        wb_en_in   = 1'b1;
        alu_result = 32'h0;
        dest_in    = 4'h5;
        st_val_in  = 32'h0000_00A5;
        tick();
        check_regs("first", 1, 1, 0, 0, 32'h0, 32'h0000_00A5, 4'h5, 4'b1000, 16'd1);

        // ---- Condition-failed S store (NE with Z=1) ----
        idle_inputs();
        valid_in    = 1'b1;
        cond        = 4'b0001;
        s_in        = 1'b1;
        alu_sr      = 4'b0010;
        mem_w_en_in = 1'b1;
        alu_result  = 32'hDEAD_BEEF;
        st_val_in   = 32'h1234_5678;
        dest_in     = 4'h9;
        #1;
        check("ne_fail.cond_pass", 32'(cond_pass), 32'd0);
        tick();
        check_regs("ne_fail", 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h1234_5678, 4'h9, 4'b1000, 16'd1);

        // ---- Back-to-back commits ----
        idle_inputs();
        valid_in    = 1'b1;
        cond        = 4'b1110;
        mem_r_en_in = 1'b1;
        alu_result  = 32'h11;
        dest_in     = 4'h3;
        tick();
        check_regs("b2b_1", 1, 0, 1, 0, 32'h11, 32'h0, 4'h3, 4'b1000, 16'd2);
        idle_inputs();
        valid_in    = 1'b1;
        cond        = 4'b0000;            // EQ, passes on Z=1
        s_in        = 1'b1;
        alu_sr      = 4'b0001;
        mem_w_en_in = 1'b1;
        alu_result  = 32'h77;
        dest_in     = 4'h7;
        tick();
        check_regs("b2b_2", 1, 0, 0, 1, 32'h77, 32'h0, 4'h7, 4'b0001, 16'd3);

        // New flags visible the following cycle
        cond = 4'b0000; #1; check("dep_eq", 32'(cond_pass), 32'd0);
        cond = 4'b0110; #1; check("dep_vs", 32'(cond_pass), 32'd1);
        cond = 4'b1011; #1; check("dep_lt", 32'(cond_pass), 32'd1);

        // ---- Freeze for 3 cycles with changing inputs ----
        freeze   = 1'b1;
        valid_in = 1'b1;
        cond     = 4'b1110;
        s_in     = 1'b1;
        wb_en_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_result = 32'hF000_0000 + 32'(i);
            st_val_in  = 32'hE000_0000 + 32'(i);
            dest_in    = 4'(i + 10);
            alu_sr     = 4'(i + 2);
            tick();
            check_regs($sformatf("freeze%0d", i), 1, 0, 0, 1, 32'h77, 32'h0, 4'h7, 4'b0001, 16'd3);
        end
        // Release: capture resumes on the next edge
        idle_inputs();
        valid_in   = 1'b1;
        cond       = 4'b1110;
        wb_en_in   = 1'b1;
        s_in       = 1'b1;
        alu_sr     = 4'b0110;
        alu_result = 32'h1234;
        st_val_in  = 32'hCAFE;
        dest_in    = 4'h2;
        tick();
        check_regs("unfreeze", 1, 1, 0, 0, 32'h1234, 32'hCAFE, 4'h2, 4'b0110, 16'd4);

        // ---- Flush together with freeze ----
        flush       = 1'b1;
        freeze      = 1'b1;
        valid_in    = 1'b1;
        cond        = 4'b1110;
        s_in        = 1'b1;
        alu_sr      = 4'b1111;
        wb_en_in    = 1'b1;
        mem_r_en_in = 1'b1;
        mem_w_en_in = 1'b1;
        alu_result  = 32'h9999;
        st_val_in   = 32'h8888;
        dest_in     = 4'hC;
        tick();
        check_regs("flush_frz", 0, 0, 0, 0, 32'h1234, 32'hCAFE, 4'h2, 4'b0110, 16'd4);

        // ---- Reset mid-stream discards the EXE instruction ----
        idle_inputs();
        rst        = 1'b1;
        valid_in   = 1'b1;
        cond       = 4'b1110;
        s_in       = 1'b1;
        alu_sr     = 4'b1111;
        wb_en_in   = 1'b1;
        alu_result = 32'h5555;
        tick();
        check_regs("mid_rst", 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 4'h0, 16'h0);
        rst = 1'b0;

        // ---- commit_cnt wrap ----
        idle_inputs();
        valid_in = 1'b1;
        cond     = 4'b1110;
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        check("cnt_ffff", 32'(commit_cnt), 32'h0000_FFFF);
        tick();
        check("cnt_wrap", 32'(commit_cnt), 32'h0);
        cond = 4'b1111;                   // never-condition: no commit
        tick();
        check("nv_nocommit.cnt", 32'(commit_cnt), 32'h0);
        check("nv_nocommit.valid", 32'(valid_out), 32'd0);

        // ---- Sweep all conditions against all SR values ----
        for (int f = 0; f < 16; f++) begin
            idle_inputs();
            valid_in = 1'b1;
            cond     = 4'b1110;
            s_in     = 1'b1;
            alu_sr   = 4'(f);
            tick();
            check($sformatf("sweep_load%0d", f), 32'(sr_out), 32'(f));
            valid_in = 1'b0;
            s_in     = 1'b0;
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c);
                #1;
                check($sformatf("sweep_sr%0h_c%0h", f, c), 32'(cond_pass),
                      32'(ref_cond(4'(c), 4'(f))));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/exe_mem_stage.md
EXE_MEM_STAGE -- requirements
Module: exe_mem_stage

Interface
REQ-001 SHALL use one clock and synchronous active-high reset: clk, rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 freeze  input  1  hazard stall; holds all state.
REQ-005 flush  input  1  branch-taken annul; inserts bubble.
REQ-006 valid_in  input  1  EXE slot holds a real instruction.
REQ-007 cond  input  4  ARM condition field of the EXE instruction.
REQ-008 s_in  input  1  instruction requests a status update (S bit).
REQ-009 alu_result  input  32  ALU result.
REQ-010 alu_sr  input  4  ALU flags, order {Z,C,N,V}.
REQ-011 wb_en_in, mem_r_en_in, mem_w_en_in  input  1 each  control enables.
REQ-012 dest_in  input  4  destination register index.
REQ-013 st_val_in  input  32  store data.
REQ-014 cond_pass  output  1  combinational condition result for the current EXE instruction.
REQ-015 sr_out  output  4  architectural status register, order {Z,C,N,V}.
REQ-016 valid_out, wb_en_out, mem_r_en_out, mem_w_en_out  output  1 each  registered to MEM.
REQ-017 alu_result_out  output  32;  st_val_out  output  32;  dest_out  output  4  registered to MEM.
REQ-018 commit_cnt  output  16  count of committed instructions.

Function
REQ-019 cond_pass SHALL be evaluated from the registered sr_out, not from alu_sr.
REQ-020 Codes: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 SHALL evaluate to 0.
REQ-021 commit = valid_in & cond_pass & ~flush & ~freeze.
REQ-022 Priority per edge: rst > flush > freeze > normal capture.
REQ-023 Normal edge: alu_result, st_val_in and dest_in SHALL be captured unconditionally; valid_out, wb_en_out, mem_r_en_out and mem_w_en_out SHALL take their inputs ANDed with commit.
REQ-024 Flush edge: valid_out and all enables SHALL become 0; data outputs SHALL hold; sr_out SHALL hold; this applies even when freeze=1.
REQ-025 Freeze edge (flush=0): every register, including sr_out and commit_cnt, SHALL hold.
REQ-026 sr_out SHALL load alu_sr on the edge where commit & s_in; otherwise it SHALL hold.
REQ-027 A condition-failed instruction SHALL not update sr_out, even when s_in=1.
REQ-028 commit_cnt SHALL increment by 1 on each commit edge and wrap from 0xFFFF to 0x0000.
REQ-029 Latency: 1 cycle from the EXE inputs to the registered outputs; back-to-back instructions SHALL be accepted every cycle.
REQ-030 Flag dependence: an S instruction in cycle n SHALL affect cond_pass from cycle n+1.

Reset
REQ-031 On an rst edge, all registered outputs SHALL become 0, including sr_out=0000 and commit_cnt=0; rst SHALL override freeze and flush.
REQ-032 After reset, cond_pass SHALL reflect sr_out=0000 (EQ=0, NE=1, AL=1).
REQ-033 rst asserted mid-stream SHALL discard the instruction in the EXE slot; no partial SR update SHALL occur.

Verification
REQ-034 After reset, valid_in=1, cond=1110, s_in=1, alu_sr=1000, wb_en_in=1, alu_result=0x0 -> next cycle: sr_out=1000, wb_en_out=1, valid_out=1, commit_cnt=1.
REQ-035 With sr_out=1000, valid_in=1, cond=0001 (NE), s_in=1, alu_sr=0010, mem_w_en_in=1 -> cond_pass=0; next cycle: mem_w_en_out=0, valid_out=0, sr_out stays 1000, commit_cnt unchanged.
REQ-036 freeze=1 for 3 cycles with changing inputs -> all outputs, sr_out and commit_cnt identical across the 3 cycles; on release, capture resumes the next edge.
REQ-037 flush=1 and freeze=1 together, valid_in=1, cond=1110 -> next cycle: valid_out=0, all enables 0, sr_out unchanged, commit_cnt unchanged.
REQ-038 commit_cnt preloaded to 0xFFFF via 65535 commits, then one more commit -> commit_cnt=0x0000.
REQ-039 Sweep all 16 cond codes against all 16 sr_out values -> cond_pass matches the REQ-020 table; 1111 always yields 0.
